// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (parity = ^data).
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       txout
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          txout_next, ready_next, done_next;
  logic          accept, bit_end;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  assign accept  = tx_valid && tx_ready;
  assign bit_end = (baud_cnt == LAST);

  // Valid/ready: a byte moves when tx_valid && tx_ready are both high at a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txout    <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      txout    <= txout_next;
      tx_ready <= ready_next;
      tx_done  <= done_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)       parity_q <= 1'b0;
    else if (accept) parity_q <= ^tx_data;
  end
`endif

  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    shift_next = shift;
    baud_next  = (state == S_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
    case (state)
      S_IDLE: begin
        bit_next = '0;
        if (accept) begin
          state_next = S_START;
          shift_next = tx_data;
        end
      end
      S_START: if (bit_end) state_next = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            shift_next = shift >> 1;
            bit_next   = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_next = S_STOP;
`endif
      S_STOP: if (bit_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with it.
  always_comb begin
    txout_next = 1'b1;
    case (state_next)
      S_START:  txout_next = 1'b0;
      S_DATA:   txout_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txout_next = parity_q;
`endif
      default:  txout_next = 1'b1;
    endcase
    ready_next = (state_next == S_IDLE);
    done_next  = (state == S_STOP) && (state_next == S_IDLE);
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: random and directed bytes, scoreboard queue, line monitor.
module tb_uart_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, txout;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .txout(txout)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         frames_done = 0;
  bit         mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!reset && tx_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Reference frame in transmit order: bit 0 is the start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  task automatic run_frame();
    logic [10:0] got_bits, expb;
    logic [7:0]  b;
    bit          busy_bad, aborted;
    got_bits = '1;
    busy_bad = 1'b0;
    aborted  = 1'b0;
    mon_busy = 1'b1;
    start_q.push_back(cyc);
    check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
    b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    expb = frame_of(b);
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c > 0) @(negedge clk);
      if (reset) begin
        aborted = 1'b1;
        break;
      end
      if (tx_ready !== 1'b0 || tx_done !== 1'b0) busy_bad = 1'b1;
      if (c % CPB == CPB / 2) got_bits[c / CPB] = txout;
    end
    if (!aborted) begin
      @(negedge clk);
      check("busy_flags_low", 32'(busy_bad), 32'd0);
      check("frame_bits", 32'(got_bits[NBITS-1:0]), 32'(expb[NBITS-1:0]));
      check("done_pulse", 32'(tx_done), 32'd1);
      check("ready_after_stop", 32'(tx_ready), 32'd1);
      frames_done++;
    end
    mon_busy = 1'b0;
  endtask

  // Line monitor: a falling edge on an idle line starts a frame.
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) prev = 1'b1;
      else begin
        if (prev === 1'b1 && txout === 1'b0) run_frame();
        prev = txout;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit hold);
    int waited;
    waited = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      check("accept_timeout", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    tx_data = 8'($urandom);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy || tx_ready !== 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_txout", 32'(txout), 32'd1);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_done", 32'(tx_done), 32'd0);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_txout", 32'(txout), 32'd1);
      check("idle_ready", 32'(tx_ready), 32'd1);
    end

    send(8'hA5, 1'b0);
    wait_idle();
    send(8'h07, 1'b0);
    send(8'h00, 1'b0);
    wait_idle();

    start_q.delete();
    send(8'hFF, 1'b1);
    send(8'h3C, 1'b0);
    wait_idle();
    check("b2b_spacing", (start_q.size() == 2) ? 32'(start_q[1] - start_q[0]) : 32'hFFFF_FFFF,
          32'(FRAME_CYC + 1));

    // A request while busy must be dropped, and data changes must not leak in.
    send(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    @(negedge clk);
    check("busy_ready_low", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      tx_data = 8'($urandom);
    end
    wait_idle();

    send(8'hA5, 1'b0);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_txout", 32'(txout), 32'd1);
    check("abort_ready", 32'(tx_ready), 32'd1);
    check("abort_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(8'h81, 1'b0);
    wait_idle();

    repeat (20) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send(8'($urandom), 1'($urandom_range(0, 1)));
    end
    tx_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(frames_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises one byte per request onto the UART TX line.
- Frame format: start bit (0), 8 data bits LSB first, parity bit, stop bit (1).
- The parity bit is the XOR-reduction of the 8 data bits, so it matches the receiver-side check `rxin == ^data`.
- Sits between the host byte interface and the TX pin; it is the transmit counterpart of the receiver SIPO/parity-check path.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200). Must be >= 2. Baud counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  reset, synchronous, active-high
- tx_valid  input  1  host requests transmission of tx_data
- tx_data  input  8  byte to send, sampled only on acceptance
- tx_ready  output  1  block idle and able to accept a byte
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes
- txout  output  1  serial line, registered, idle high

Behaviour:
- Reset (synchronous): state=IDLE, txout=1, tx_ready=1, tx_done=0. Baud counter, bit index and shift register are cleared.
- Reset mid-frame: the frame is aborted with no tx_done. After the reset edge, txout=1 and tx_ready=1.
- Handshake: a byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge.
  - The parity bit is computed from the latched byte.
- tx_valid while tx_ready=0 is ignored and not queued. tx_data changes after acceptance have no effect.
- States and transitions:
  - IDLE: txout=1, tx_ready=1. Goes to START on acceptance.
  - START: txout=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: txout=shift[0]; shift right every CLKS_PER_BIT cycles. After bit index 7 completes, go to PARITY (or STOP if the macro is off).
  - PARITY: txout=^latched_byte for CLKS_PER_BIT cycles, then STOP.
  - STOP: txout=1 for CLKS_PER_BIT cycles. On its last cycle's edge, go to IDLE with tx_done=1 for exactly one cycle and tx_ready=1.
- Timing:
  - txout changes on the edge following acceptance (start bit begins one cycle after the accept edge).
  - tx_ready drops on the same edge.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit and wraps to 0 at bit boundaries.
  - Held at 0 in IDLE.
- Frame length: 11*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the stop bit (10*CLKS_PER_BIT without parity).
- Back-to-back with tx_valid held high: the next byte is accepted on the first edge where tx_ready=1. There is exactly one idle-high cycle between the stop bit and the next start bit, so start-to-start spacing is 11*CLKS_PER_BIT+1 cycles.
- tx_done and tx_ready are never high during START/DATA/PARITY/STOP, except that tx_done is asserted in the first IDLE cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined: the PARITY state is present. Frame is 11 bits; parity bit = ^data (even total count of ones across data+parity).
- Undefined: the PARITY state and its logic are removed. DATA goes directly to STOP; frame is 10 bits, 10*CLKS_PER_BIT cycles, start-to-start 10*CLKS_PER_BIT+1.

Test Plan (CLKS_PER_BIT=4, UART_TX_PARITY_EN defined unless noted):
1. Reset for 3 cycles, tx_valid=0 -> txout=1, tx_ready=1, tx_done=0 throughout; held after reset release.
2. Send 0xA5 -> txout per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. tx_ready low for 44 cycles; tx_done pulses once in the following cycle.
3. Send 0x07 (three ones) -> parity bit 1. Send 0x00 -> parity 0. Bit windows each exactly 4 cycles, sampled mid-bit.
4. tx_valid held high, tx_data=0xFF then 0x3C switched on the acceptance edge -> frames 0xFF (parity 0) and 0x3C (parity 0); start bits 45 cycles apart; two tx_done pulses.
5. Pulse tx_valid with 0x55 during the data phase of a 0xA5 frame, and change tx_data mid-frame -> 0xA5 frame unchanged, 0x55 never sent. Assert reset during data bit 3 -> txout=1 next cycle, no tx_done; a subsequent 0x81 frame is correct.
6. UART_TX_PARITY_EN undefined, send 0xA5 -> start, 8 data bits, stop; 40 cycles; no parity bit; tx_done at end.
